// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: control, program-load port and instruction output handshake.
// master is the fetch unit side, slave is the driver/consumer side.
interface instruction_fetch_unit_if #(
    parameter int PC_WIDTH   = 8,
    parameter int INST_WIDTH = 32
);
    logic                  start;
    logic                  branch_en;
    logic [PC_WIDTH-1:0]   branch_target;
    logic                  prog_we;
    logic [PC_WIDTH-1:0]   prog_addr;
    logic [INST_WIDTH-1:0] prog_wdata;
    logic                  inst_ready;
    logic                  inst_valid;
    logic [INST_WIDTH-1:0] inst_out;
    logic [PC_WIDTH-1:0]   inst_pc;
    logic [PC_WIDTH-1:0]   pc;
    logic                  halted;

    modport master (
        input  start, branch_en, branch_target,
        input  prog_we, prog_addr, prog_wdata,
        input  inst_ready,
        output inst_valid, inst_out, inst_pc, pc, halted
    );

    modport slave (
        output start, branch_en, branch_target,
        output prog_we, prog_addr, prog_wdata,
        output inst_ready,
        input  inst_valid, inst_out, inst_pc, pc, halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: register-array instruction memory, one fetch per
// cycle into a single output slot, branch flush and halt-on-marker word.
module instruction_fetch_unit #(
    parameter int                    PC_WIDTH   = 8,
    parameter int                    INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0] HALT_WORD  = '1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instruction_fetch_unit_if.master bus
);
    localparam int DEPTH = 2 ** PC_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    logic [INST_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   ipc_q, ipc_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic [INST_WIDTH-1:0] fetch_word;
    logic                  slot_free;

    // Memory is not reset; read is asynchronous so a same-cycle write
    // is only seen by the next fetch.
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            mem[bus.prog_addr] <= bus.prog_wdata;
        end
    end

    assign fetch_word = mem[pc_q];
    assign slot_free  = !valid_q || bus.inst_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                end
            end
            RUN: begin
                if (bus.branch_en) begin
                    pc_d    = bus.branch_target;
                    valid_d = 1'b0;
                end else if (slot_free) begin
                    inst_d  = fetch_word;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    // The halt marker is delivered but pc stays on it.
                    if (fetch_word == HALT_WORD) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                    valid_d = 1'b0;
                end else if (bus.inst_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.inst_valid = valid_q;
    assign bus.inst_out   = inst_q;
    assign bus.inst_pc    = ipc_q;
    assign bus.pc         = pc_q;
    assign bus.halted     = (state_q == HALT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized
// stream checked against an address/acceptance model.
module tb_instruction_fetch_unit;
    localparam int PW = 8;
    localparam int IW = 32;
    localparam logic [IW-1:0] HW = '1;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    logic [IW-1:0] prog [4];
    logic [IW-1:0] mdl [256];

    instruction_fetch_unit_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) bus ();

    instruction_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic prog_write(input logic [PW-1:0] a, input logic [IW-1:0] d);
        @(negedge clk);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = a;
        bus.prog_wdata = d;
        @(negedge clk);
        bus.prog_we    = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 0; bus.branch_en = 0; bus.branch_target = '0;
        bus.prog_we = 0; bus.prog_addr = '0; bus.prog_wdata = '0;
        bus.inst_ready = 0;
        repeat (2) @(negedge clk);
        n_chk++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0h want 0", bus.inst_valid); end
        n_chk++; if (bus.inst_out !== '0) begin n_fail++; $display("FAIL rst_out got %0h want 0", bus.inst_out); end
        n_chk++; if (bus.inst_pc !== '0) begin n_fail++; $display("FAIL rst_ipc got %0h want 0", bus.inst_pc); end
        n_chk++; if (bus.pc !== '0) begin n_fail++; $display("FAIL rst_pc got %0h want 0", bus.pc); end
        n_chk++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %0h want 0", bus.halted); end
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %0h want 0", bus.inst_valid); end
        n_chk++; if (bus.pc !== '0) begin n_fail++; $display("FAIL idle_pc got %0h want 0", bus.pc); end
    endtask

    task automatic test_program();
        prog[0] = 32'h04; prog[1] = 32'h2104; prog[2] = 32'h82000; prog[3] = HW;
        for (int i = 0; i < 4; i++) prog_write(i[PW-1:0], prog[i]);
        bus.inst_ready = 1'b1;
        pulse_start();
        n_chk++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL lat_valid got %0h want 0", bus.inst_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %0h want 1", i, bus.inst_valid); end
            n_chk++; if (bus.inst_pc !== i[PW-1:0]) begin n_fail++; $display("FAIL seq_ipc[%0d] got %0h want %0h", i, bus.inst_pc, i); end
            n_chk++; if (bus.inst_out !== prog[i]) begin n_fail++; $display("FAIL seq_out[%0d] got %0h want %0h", i, bus.inst_out, prog[i]); end
            n_chk++; if (bus.halted !== (i == 3)) begin n_fail++; $display("FAIL seq_halted[%0d] got %0h want %0h", i, bus.halted, (i == 3)); end
        end
        n_chk++; if (bus.pc !== 8'd3) begin n_fail++; $display("FAIL halt_pc got %0h want 3", bus.pc); end
        bus.inst_ready = 1'b0;
        bus.branch_en = 1'b1;
        bus.branch_target = 8'h40;
        @(negedge clk);
        bus.branch_en = 1'b0;
        n_chk++; if (bus.pc !== 8'd3) begin n_fail++; $display("FAIL halt_br_pc got %0h want 3", bus.pc); end
        n_chk++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL halt_hold got %0h want 1", bus.inst_valid); end
        n_chk++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_stay got %0h want 1", bus.halted); end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_accept got %0h want 0", bus.inst_valid); end
    endtask

    task automatic test_stall();
        bus.inst_ready = 1'b0;
        pulse_start();
        n_chk++; if (bus.pc !== 8'd0) begin n_fail++; $display("FAIL restart_pc got %0h want 0", bus.pc); end
        n_chk++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL restart_halted got %0h want 0", bus.halted); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++; if (bus.inst_out !== 32'h04) begin n_fail++; $display("FAIL stall_out[%0d] got %0h want 4", i, bus.inst_out); end
            n_chk++; if (bus.pc !== 8'd1) begin n_fail++; $display("FAIL stall_pc[%0d] got %0h want 1", i, bus.pc); end
        end
        bus.inst_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            n_chk++; if (bus.inst_pc !== i[PW-1:0] || bus.inst_out !== prog[i]) begin n_fail++; $display("FAIL resume[%0d] got %0h/%0h want %0h/%0h", i, bus.inst_pc, bus.inst_out, i, prog[i]); end
        end
        @(negedge clk);
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL resume_halt got %0h/%0h want 0/1", bus.inst_valid, bus.halted); end
    endtask

    task automatic test_branch_stall();
        prog_write(8'h80, 32'h13);
        bus.inst_ready = 1'b0;
        pulse_start();
        @(negedge clk);
        n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 8'd0) begin n_fail++; $display("FAIL br_pre got %0h/%0h want 1/0", bus.inst_valid, bus.inst_pc); end
        bus.branch_en = 1'b1;
        bus.branch_target = 8'h80;
        @(negedge clk);
        bus.branch_en = 1'b0;
        n_chk++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush got %0h want 0", bus.inst_valid); end
        n_chk++; if (bus.pc !== 8'h80) begin n_fail++; $display("FAIL br_pc got %0h want 80", bus.pc); end
        @(negedge clk);
        n_chk++; if (bus.inst_pc !== 8'h80 || bus.inst_out !== 32'h13) begin n_fail++; $display("FAIL br_target got %0h/%0h want 80/13", bus.inst_pc, bus.inst_out); end
    endtask

    task automatic test_wrap();
        prog_write(8'hFE, 32'hFE00);
        prog_write(8'hFF, 32'hFF00);
        bus.inst_ready = 1'b1;
        bus.branch_en = 1'b1;
        bus.branch_target = 8'hFE;
        @(negedge clk);
        bus.branch_en = 1'b0;
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.pc !== 8'hFE) begin n_fail++; $display("FAIL wrap_br got %0h/%0h want 0/fe", bus.inst_valid, bus.pc); end
        @(negedge clk);
        n_chk++; if (bus.inst_pc !== 8'hFE || bus.inst_out !== 32'hFE00) begin n_fail++; $display("FAIL wrap_fe got %0h/%0h", bus.inst_pc, bus.inst_out); end
        @(negedge clk);
        n_chk++; if (bus.inst_pc !== 8'hFF || bus.inst_out !== 32'hFF00) begin n_fail++; $display("FAIL wrap_ff got %0h/%0h", bus.inst_pc, bus.inst_out); end
        @(negedge clk);
        n_chk++; if (bus.inst_pc !== 8'h00 || bus.inst_out !== 32'h04) begin n_fail++; $display("FAIL wrap_00 got %0h/%0h", bus.inst_pc, bus.inst_out); end
        n_chk++; if (bus.pc !== 8'h01) begin n_fail++; $display("FAIL wrap_pc got %0h want 1", bus.pc); end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.inst_valid !== 1'b0 || bus.inst_out !== '0 || bus.inst_pc !== '0) begin n_fail++; $display("FAIL areset_out got %0h/%0h/%0h want 0/0/0", bus.inst_valid, bus.inst_out, bus.inst_pc); end
        n_chk++; if (bus.pc !== '0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL areset_pc got %0h/%0h want 0/0", bus.pc, bus.halted); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++; if (bus.inst_pc !== i[PW-1:0] || bus.inst_out !== prog[i]) begin n_fail++; $display("FAIL keep_mem[%0d] got %0h/%0h want %0h/%0h", i, bus.inst_pc, bus.inst_out, i, prog[i]); end
        end
        n_chk++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL keep_halt got %0h want 1", bus.halted); end
    endtask

    task automatic test_restart_rdw();
        bus.inst_ready = 1'b1;
        pulse_start();
        bus.prog_we = 1'b1;
        bus.prog_addr = 8'h00;
        bus.prog_wdata = 32'h5555;
        @(negedge clk);
        bus.prog_we = 1'b0;
        n_chk++; if (bus.inst_pc !== 8'h00 || bus.inst_out !== 32'h04) begin n_fail++; $display("FAIL rdw_old got %0h/%0h want 0/4", bus.inst_pc, bus.inst_out); end
        repeat (3) @(negedge clk);
        n_chk++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL rdw_halt got %0h want 1", bus.halted); end
        pulse_start();
        @(negedge clk);
        n_chk++; if (bus.inst_pc !== 8'h00 || bus.inst_out !== 32'h5555) begin n_fail++; $display("FAIL rdw_new got %0h/%0h want 0/5555", bus.inst_pc, bus.inst_out); end
    endtask

    task automatic test_random();
        logic [PW-1:0] m_exp;
        logic          m_valid;
        logic          rdy;
        logic          br;
        logic [PW-1:0] tgt;
        rst_n = 1'b0;
        bus.inst_ready = 1'b0;
        bus.branch_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 256; a++) begin
            mdl[a] = $urandom();
            if (mdl[a] == HW) mdl[a] = 32'h1;
            prog_write(a[PW-1:0], mdl[a]);
        end
        pulse_start();
        m_exp = '0;
        m_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            n_chk++;
            if (bus.inst_valid !== m_valid || bus.halted !== 1'b0) begin
                n_fail++; $display("FAIL rnd_valid[%0d] got %0h/%0h want %0h/0", c, bus.inst_valid, bus.halted, m_valid);
            end else if (m_valid && (bus.inst_pc !== m_exp || bus.inst_out !== mdl[m_exp] || bus.pc !== m_exp + 8'd1)) begin
                n_fail++; $display("FAIL rnd_data[%0d] got %0h/%0h/%0h want %0h/%0h/%0h", c, bus.inst_pc, bus.inst_out, bus.pc, m_exp, mdl[m_exp], m_exp + 8'd1);
            end else if (!m_valid && bus.pc !== m_exp) begin
                n_fail++; $display("FAIL rnd_pc[%0d] got %0h want %0h", c, bus.pc, m_exp);
            end
            rdy = ($urandom_range(0, 99) < 60);
            br  = ($urandom_range(0, 99) < 10);
            tgt = $urandom_range(0, 255);
            bus.inst_ready = rdy;
            bus.branch_en = br;
            bus.branch_target = tgt;
            if (br) begin
                m_exp = tgt;
                m_valid = 1'b0;
            end else begin
                if (m_valid && rdy) m_exp = m_exp + 8'd1;
                m_valid = 1'b1;
            end
            @(negedge clk);
        end
        bus.branch_en = 1'b0;
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_program();
        test_stall();
        test_branch_stall();
        test_wrap();
        test_async_reset();
        test_restart_rdw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named `clk` and `rst_n`.
REQ-002 Parameter PC_WIDTH, default 8: program counter width; instruction memory depth DEPTH = 2**PC_WIDTH.
REQ-003 Parameter INST_WIDTH, default 32: instruction word width.
REQ-004 Parameter RESET_PC, default 0: start address after reset and restart.
REQ-005 Parameter HALT_WORD, default all-ones of INST_WIDTH: fetched value that halts the unit.
REQ-006 Port `clk`, input, 1: rising-edge clock.
REQ-007 Port `rst_n`, input, 1: asynchronous active-low reset.
REQ-008 Port `start`, input, 1: begin fetching, sampled in IDLE or HALT.
REQ-009 Port `branch_en`, input, 1: redirect fetch, sampled in RUN only.
REQ-010 Port `branch_target`, input, PC_WIDTH: redirect address.
REQ-011 Port `prog_we`, input, 1: instruction memory write enable.
REQ-012 Port `prog_addr`, input, PC_WIDTH: write address.
REQ-013 Port `prog_wdata`, input, INST_WIDTH: write data.
REQ-014 Port `inst_ready`, input, 1: consumer accepts `inst_out` this cycle.
REQ-015 Port `inst_valid`, output, 1: `inst_out` and `inst_pc` hold a fetched instruction.
REQ-016 Port `inst_out`, output, INST_WIDTH: fetched instruction.
REQ-017 Port `inst_pc`, output, PC_WIDTH: address of `inst_out`.
REQ-018 Port `pc`, output, PC_WIDTH: next fetch address.
REQ-019 Port `halted`, output, 1: high while the unit is in HALT.

Function
REQ-020 The instruction memory SHALL be a DEPTH x INST_WIDTH register array, written on the rising edge when `prog_we`=1, in any state.
REQ-021 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-022 The FSM SHALL have states IDLE, RUN and HALT.
REQ-023 IDLE SHALL transition to RUN when `start`=1; `pc` is held at RESET_PC.
REQ-024 The output slot is free when `inst_valid`=0 or `inst_ready`=1.
REQ-025 In RUN with the slot free and `branch_en`=0, each edge SHALL set: `inst_out`<=mem[pc], `inst_pc`<=pc, `inst_valid`<=1, `pc`<=pc+1 modulo DEPTH (wrap DEPTH-1 to 0).
REQ-026 In RUN with the slot free and no branch, `inst_valid` SHALL stay asserted on consecutive edges (one instruction per cycle).
REQ-027 In RUN with `inst_valid`=1 and `inst_ready`=0, `inst_out`, `inst_pc`, `inst_valid` and `pc` SHALL hold.
REQ-028 In RUN with `branch_en`=1, regardless of the slot, the edge SHALL set `pc`<=branch_target and `inst_valid`<=0 (flush), with no fetch in that cycle.
REQ-029 The first fetch after a branch SHALL read branch_target on the following edge.
REQ-030 When a fetch loads a word equal to HALT_WORD, that word SHALL be presented with `inst_valid`=1, the FSM SHALL enter HALT on the same edge, and `pc` SHALL not advance.
REQ-031 In HALT, no fetches occur, `branch_en` is ignored, and a pending `inst_valid` SHALL hold until accepted.
REQ-032 HALT SHALL transition to RUN when `start`=1, setting `pc`<=RESET_PC and `inst_valid`<=0.
REQ-033 `halted` SHALL be 1 exactly when state is HALT.
REQ-034 Latency SHALL be: `start` sampled at edge k gives the first `inst_valid`=1 after edge k+1 with `inst_pc`=RESET_PC.

Reset
REQ-035 On `rst_n`=0 the block SHALL immediately set state=IDLE, `pc`=RESET_PC, `inst_valid`=0, `inst_out`=0, `inst_pc`=0 and `halted`=0, independent of `clk`, including mid-fetch or mid-stall.
REQ-036 Instruction memory contents SHALL NOT be cleared by reset.
REQ-037 After `rst_n` deasserts, the block SHALL remain in IDLE until `start`=1.

Verification
REQ-038 Load mem[0..3]={0x04,0x2104,0x82000,HALT_WORD}, pulse `start`, `inst_ready`=1 -> `inst_pc` 0,1,2,3 on consecutive cycles, `halted`=1 after the 4th word, `pc`=3.
REQ-039 Hold `inst_ready`=0 for 3 cycles after the first valid -> `inst_out`=0x04 and `pc`=1 stable; on release the stream continues at address 1 with no loss or duplicate.
REQ-040 Assert `branch_en` with target 0x80 while `inst_valid`=1 and `inst_ready`=0 -> `inst_valid`=0 next cycle, then `inst_pc`=0x80.
REQ-041 PC_WIDTH=8, start at pc=0xFE with no halt -> `inst_pc` sequence 0xFE,0xFF,0x00.
REQ-042 Assert `rst_n`=0 mid-stream between clock edges -> outputs reach reset values immediately; memory contents are preserved.
REQ-043 Apply `start` in HALT -> the unit refetches from RESET_PC; `prog_we` to the currently read address returns the old word that cycle.
